panel_cmdgen: RTL

Front-panel command generator for the Kappa3 core. It conditions the three raw push buttons (run, step-phase, step-instruction) and drives the single-cycle `run` / `step_phase` / `step_inst` command pulses into the phase generator. It tracks the phase generator's mode so that commands are never issued where they would be dropped. It also implements one PC breakpoint that stops free-running execution after the matching instruction completes.

---
 rtl/panel_cmdgen_pkg.sv | 38 +++
 rtl/panel_cmdgen_btn_debounce.sv | 63 ++++++
 rtl/panel_cmdgen.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/panel_cmdgen_pkg.sv
// panel_cmdgen_pkg
// Shared definitions for the front-panel command generator:
//   - mode_e     : mode FSM state encoding (IDLE, FREE_RUN, STEPPING, HOLD)
//   - PH_*       : one-hot phase constants as driven by the phase generator
//   - cmd_e      : a resolved panel command, one per cycle at most
//   - pick_cmd() : resolves coincident press events by priority
package panel_cmdgen_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE     = 2'd0,
        MODE_FREE_RUN = 2'd1,
        MODE_STEPPING = 2'd2,
        MODE_HOLD     = 2'd3
    } mode_e;

    localparam logic [3:0] PH_IF = 4'b0001;
    localparam logic [3:0] PH_DE = 4'b0010;
    localparam logic [3:0] PH_EX = 4'b0100;
    localparam logic [3:0] PH_WB = 4'b1000;

    typedef enum logic [1:0] {
        CMD_NONE       = 2'd0,
        CMD_RUN        = 2'd1,
        CMD_STEP_INST  = 2'd2,
        CMD_STEP_PHASE = 2'd3
    } cmd_e;

    // Priority: run > step_inst > step_phase. Losing events are dropped.
    function automatic cmd_e pick_cmd(input logic run_evt,
                                      input logic inst_evt,
                                      input logic phase_evt);
        if (run_evt)        return CMD_RUN;
        else if (inst_evt)  return CMD_STEP_INST;
        else if (phase_evt) return CMD_STEP_PHASE;
        else                return CMD_NONE;
    endfunction

endpackage

// File: rtl/panel_cmdgen_btn_debounce.sv
// btn_debounce
// Conditions one raw asynchronous push button.
//   clock, reset : system clock, async active-low reset
//   btn_in       : raw button level, asynchronous to clock
//   press        : one-cycle pulse on a rising edge of the debounced level
// Path: 2-flop synchronizer -> stability counter -> debounced level -> edge.
module btn_debounce #(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    output logic press
);

    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEB_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             deb_q, deb_d;
    logic             deb_prev_q, deb_prev_d;
    logic [DEB_W-1:0] cnt_q, cnt_d;

    // The counter only runs while the synchronized level differs from the
    // accepted level. With two levels, any change of the synchronized level
    // during a count makes it equal to the accepted level again, which
    // clears the counter, so a bounce restarts the stability window.
    always_comb begin
        sync1_d    = btn_in;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        cnt_d      = cnt_q;
        if (sync2_q == deb_q) begin
            cnt_d = '0;
        end else if (cnt_q == DEB_MAX) begin
            deb_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + DEB_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q      <= cnt_d;
        end
    end

    assign press = deb_q & ~deb_prev_q;

endmodule

// File: rtl/panel_cmdgen.sv
// panel_cmdgen
// Front-panel command generator for the Kappa3 core.
//   clock, reset                   : system clock, async active-low reset
//   btn_run/step_phase/step_inst   : raw push buttons (asynchronous)
//   bp_enable, bp_addr, pc         : single PC breakpoint
//   cstate, running                : phase generator status
//   run, step_phase, step_inst     : registered one-cycle command pulses
//   bp_hit                         : sticky, last stop came from the breakpoint
// The mode FSM tracks the phase generator so commands are only issued where
// they take effect; HOLD absorbs the one-edge lag before `running` updates.
module panel_cmdgen
    import panel_cmdgen_pkg::*;
#(
    parameter int DEB_CYCLES = 50000,
    parameter int DEB_W      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        btn_run,
    input  logic        btn_step_phase,
    input  logic        btn_step_inst,
    input  logic        bp_enable,
    input  logic [31:0] bp_addr,
    input  logic [31:0] pc,
    input  logic [3:0]  cstate,
    input  logic        running,
    output logic        run,
    output logic        step_phase,
    output logic        step_inst,
    output logic        bp_hit
);

    logic  run_evt, inst_evt, phase_evt;
    cmd_e  cmd;
    logic  bp_match;

    mode_e state_q, state_d;
    mode_e hold_next_q, hold_next_d;
    logic  run_q, run_d;
    logic  step_phase_q, step_phase_d;
    logic  step_inst_q, step_inst_d;
    logic  bp_hit_q, bp_hit_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_run (
        .clock(clock), .reset(reset), .btn_in(btn_run), .press(run_evt)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_inst (
        .clock(clock), .reset(reset), .btn_in(btn_step_inst), .press(inst_evt)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb_phase (
        .clock(clock), .reset(reset), .btn_in(btn_step_phase), .press(phase_evt)
    );

    assign cmd = pick_cmd(run_evt, inst_evt, phase_evt);

    // Match in the WB cycle: the instruction at bp_addr has completed once
    // the registered run pulse lands in the following IF cycle.
    assign bp_match = bp_enable & running & (cstate == PH_WB) & (pc == bp_addr);

    always_comb begin
        state_d      = state_q;
        hold_next_d  = hold_next_q;
        run_d        = 1'b0;
        step_phase_d = 1'b0;
        step_inst_d  = 1'b0;
        bp_hit_d     = bp_hit_q;
        case (state_q)
            MODE_IDLE: begin
                case (cmd)
                    CMD_RUN: begin
                        run_d       = 1'b1;
                        bp_hit_d    = 1'b0;
                        state_d     = MODE_HOLD;
                        hold_next_d = MODE_FREE_RUN;
                    end
                    CMD_STEP_INST: begin
                        step_inst_d = 1'b1;
                        bp_hit_d    = 1'b0;
                        state_d     = MODE_HOLD;
                        hold_next_d = MODE_STEPPING;
                    end
                    CMD_STEP_PHASE: begin
                        step_phase_d = 1'b1;
                        bp_hit_d     = 1'b0;
                        state_d      = MODE_HOLD;
                        hold_next_d  = MODE_STEPPING;
                    end
                    default: ;
                endcase
            end
            MODE_FREE_RUN: begin
                // Breakpoint first: a coincident run press folds into the
                // same single stop pulse, and the stop is attributed to it.
                if (bp_match) begin
                    run_d       = 1'b1;
                    bp_hit_d    = 1'b1;
                    state_d     = MODE_HOLD;
                    hold_next_d = MODE_IDLE;
                end else if (cmd == CMD_RUN) begin
                    run_d       = 1'b1;
                    state_d     = MODE_HOLD;
                    hold_next_d = MODE_IDLE;
                end else if (!running) begin
                    state_d = MODE_IDLE;
                end
            end
            MODE_STEPPING: begin
                if (!running) state_d = MODE_IDLE;
            end
            MODE_HOLD: begin
                state_d = hold_next_q;
            end
            default: state_d = MODE_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= MODE_IDLE;
            hold_next_q  <= MODE_IDLE;
            run_q        <= 1'b0;
            step_phase_q <= 1'b0;
            step_inst_q  <= 1'b0;
            bp_hit_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_next_q  <= hold_next_d;
            run_q        <= run_d;
            step_phase_q <= step_phase_d;
            step_inst_q  <= step_inst_d;
            bp_hit_q     <= bp_hit_d;
        end
    end

    assign run        = run_q;
    assign step_phase = step_phase_q;
    assign step_inst  = step_inst_q;
    assign bp_hit     = bp_hit_q;

endmodule
